// File: rtl/matmul_pkg.sv
// Shared definitions for the sequential matrix-multiply engine: FSM states,
// default dimensions and counter-width helpers.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int ROWS_DEF   = 2;
  localparam int INNER_DEF  = 4;
  localparam int COLS_DEF   = 2;

  // A dimension of 1 still needs a 1-bit counter so the index stays a legal vector.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_CNT_W   = cnt_w(ROWS_DEF);
  localparam int COL_CNT_W   = cnt_w(COLS_DEF);
  localparam int INNER_CNT_W = cnt_w(INNER_DEF);

endpackage

// File: rtl/matmul_seq_if.sv
// CSR-side bundle of the matrix engine: operands and start in, result and status out.
interface matmul_seq_if
  import matmul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int INNER  = INNER_DEF,
  parameter int COLS   = COLS_DEF
);

  logic                                    start_i;
  logic [ROWS-1:0][INNER-1:0][DATA_W-1:0]  mat1_i;
  logic [INNER-1:0][COLS-1:0][DATA_W-1:0]  mat2_i;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]   res_o;
  logic                                    busy_o;
  logic                                    ready_o;

  modport master (
    output start_i, mat1_i, mat2_i,
    input  res_o, busy_o, ready_o
  );

  modport slave (
    input  start_i, mat1_i, mat2_i,
    output res_o, busy_o, ready_o
  );

endinterface

// File: rtl/mac_unit.sv
// Combinational multiply-accumulate, a*b+acc, wrapping modulo 2^DATA_W.
module mac_unit #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] acc_i,
  output logic [DATA_W-1:0] sum_o
);

  // All operands share DATA_W, so the product is truncated before the add.
  assign sum_o = a_i * b_i + acc_i;

endmodule

// File: rtl/matmul_seq.sv
// Sequential ROWSxINNER by INNERxCOLS matrix multiply using one shared MAC,
// k innermost, then j, then i; result published in a single DONE cycle.
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int INNER  = INNER_DEF,
  parameter int COLS   = COLS_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  matmul_seq_if.slave   bus
);

  localparam int I_W = cnt_w(ROWS);
  localparam int J_W = cnt_w(COLS);
  localparam int K_W = cnt_w(INNER);

  localparam logic [I_W-1:0] I_LAST = I_W'(ROWS - 1);
  localparam logic [J_W-1:0] J_LAST = J_W'(COLS - 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(INNER - 1);

  state_e                                 state_q;
  logic [I_W-1:0]                         i_q;
  logic [J_W-1:0]                         j_q;
  logic [K_W-1:0]                         k_q;
  logic [DATA_W-1:0]                      acc_q;
  logic [ROWS-1:0][INNER-1:0][DATA_W-1:0] a_q;
  logic [INNER-1:0][COLS-1:0][DATA_W-1:0] b_q;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]  shadow_q;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]  res_q;
  logic                                   busy_q;
  logic                                   ready_q;
  logic [DATA_W-1:0]                      mac_d;

  logic accept;
  logic last_term;

  assign accept    = (state_q == IDLE) && bus.start_i;
  assign last_term = (state_q == CALC) && (k_q == K_LAST);

  mac_unit #(.DATA_W(DATA_W)) u_mac (
    .a_i   (a_q[i_q][k_q]),
    .b_i   (b_q[k_q][j_q]),
    .acc_i (acc_q),
    .sum_o (mac_d)
  );

  // NOTE: operand latches and the result shadow carry no reset; every slot is
  // rewritten before it is read, so resetting them would only cost routing.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      a_q <= bus.mat1_i;
      b_q <= bus.mat2_i;
    end
    if (last_term) begin
      shadow_q[i_q][j_q] <= mac_d;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every branch sees
  // the pre-edge values of the counters and accumulator.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (k_q == K_LAST) begin
            acc_q <= '0;
            k_q   <= '0;
            if (j_q == J_LAST) begin
              j_q <= '0;
              if (i_q == I_LAST) begin
                i_q     <= '0;
                state_q <= DONE;
              end else begin
                i_q <= i_q + 1'b1;
              end
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            acc_q <= mac_d;
            k_q   <= k_q + 1'b1;
          end
        end
        DONE: begin
          res_q   <= shadow_q;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.res_o   = res_q;
  assign bus.busy_o  = busy_q;
  assign bus.ready_o = ready_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Scoreboard bench for matmul_seq: expected products are queued at start and
// compared when ready_o rises.
module tb_matmul_seq;
  import matmul_pkg::*;

  typedef logic [ROWS_DEF-1:0][INNER_DEF-1:0][DATA_W_DEF-1:0] m1_t;
  typedef logic [INNER_DEF-1:0][COLS_DEF-1:0][DATA_W_DEF-1:0] m2_t;
  typedef logic [ROWS_DEF-1:0][COLS_DEF-1:0][DATA_W_DEF-1:0]  res_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  res_t exp_q[$];

  matmul_seq_if bus ();

  matmul_seq dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t model(input m1_t a, input m2_t b);
    res_t r;
    logic [DATA_W_DEF-1:0] t;
    r = '0;
    for (int i = 0; i < ROWS_DEF; i++)
      for (int j = 0; j < COLS_DEF; j++)
        for (int k = 0; k < INNER_DEF; k++) begin
          t = a[i][k] * b[k][j];
          r[i][j] = r[i][j] + t;
        end
    return r;
  endfunction

  task automatic pop_compare(input string tag);
    res_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check(tag, bus.res_o, e);
    end
  endtask

  // One operation from a start pulse; poke >= 0 zeroes mat1 and re-pulses start
  // at that cycle to show both are ignored mid-calculation.
  task automatic run_op(input string tag, input m1_t a, input m2_t b, input int poke);
    int n;
    int busy_low;
    bus.mat1_i  = a;
    bus.mat2_i  = b;
    bus.start_i = 1'b1;
    exp_q.push_back(model(a, b));
    tick();
    bus.start_i = 1'b0;
    check({tag, "_busy_after_start"}, bus.busy_o, 1);
    check({tag, "_ready_cleared"}, bus.ready_o, 0);
    n = 0;
    busy_low = 0;
    while (n < 40 && !bus.ready_o) begin
      if (n == poke) begin
        bus.mat1_i  = '0;
        bus.start_i = 1'b1;
      end
      tick();
      bus.start_i = 1'b0;
      n++;
      if (!bus.ready_o && !bus.busy_o) busy_low++;
    end
    if (!bus.ready_o) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_latency"}, n, 17);
      check({tag, "_busy_gaps"}, busy_low, 0);
      check({tag, "_busy_done"}, bus.busy_o, 0);
      pop_compare({tag, "_res"});
    end
  endtask

  initial begin
    m1_t m1_mix, m1_ones;
    m2_t m2_id, m2_mix, m2_ones;
    int  ready_cnt;
    int  busy_cnt;
    int  n;

    n_checks = 0;
    n_errors = 0;
    bus.start_i = 1'b0;
    bus.mat1_i  = '0;
    bus.mat2_i  = '0;

    for (int i = 0; i < ROWS_DEF; i++)
      for (int k = 0; k < INNER_DEF; k++)
        m1_mix[i][k] = DATA_W_DEF'(i * INNER_DEF + k + 1);
    for (int k = 0; k < INNER_DEF; k++)
      for (int j = 0; j < COLS_DEF; j++) begin
        m2_id[k][j]  = (k == j) ? 32'd1 : 32'd0;
        m2_mix[k][j] = DATA_W_DEF'(k * COLS_DEF + j + 1);
      end
    m1_ones = '1;
    m2_ones = '1;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_res", bus.res_o, 0);
    check("reset_busy", bus.busy_o, 0);
    check("reset_ready", bus.ready_o, 0);

    // Hand-written constants guard the model itself.
    run_op("identity", m1_mix, m2_id, -1);
    check("identity_const", bus.res_o, {32'd6, 32'd5, 32'd2, 32'd1});
    run_op("mixed", m1_mix, m2_mix, -1);
    check("mixed_const", bus.res_o, {32'd140, 32'd114, 32'd60, 32'd50});
    run_op("wrap", m1_ones, m2_ones, -1);
    check("wrap_const", bus.res_o, {32'd4, 32'd4, 32'd4, 32'd4});

    run_op("ignore", m1_mix, m2_mix, 5);
    busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.busy_o) busy_cnt++;
    end
    check("ignore_single_completion", busy_cnt, 0);
    check("ignore_ready_sticky", bus.ready_o, 1);

    // Abort mid-calculation.
    bus.mat1_i  = m1_mix;
    bus.mat2_i  = m2_id;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_res", bus.res_o, 0);
    check("abort_ready", bus.ready_o, 0);
    check("abort_busy", bus.busy_o, 0);
    busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.busy_o || bus.ready_o) busy_cnt++;
    end
    check("abort_quiet", busy_cnt, 0);
    run_op("after_abort", m1_mix, m2_mix, -1);

    // Start held high for 40 cycles: starts accepted at 0, 18 and 36.
    bus.mat1_i  = m1_mix;
    bus.mat2_i  = m2_mix;
    bus.start_i = 1'b1;
    for (int c = 0; c < 3; c++) exp_q.push_back(model(m1_mix, m2_mix));
    tick();
    ready_cnt = 0;
    for (n = 1; n < 40; n++) begin
      tick();
      if (bus.ready_o) begin
        ready_cnt++;
        check($sformatf("b2b_ready_cycle%0d", n), (n == 17 || n == 35) ? 1 : 0, 1);
        pop_compare("b2b_res");
      end
    end
    bus.start_i = 1'b0;
    check("b2b_ready_count", ready_cnt, 2);
    n = 0;
    while (n < 40 && !bus.ready_o) begin
      tick();
      n++;
    end
    check("b2b_third_ready", bus.ready_o, 1);
    check("b2b_third_latency", n + 39, 53);
    if (bus.ready_o) pop_compare("b2b_third_res");
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
